// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port, 64-bit synchronous memory between the
//            instruction-fetch port (read-only) and the load/store data
//            port (read/write with byte strobes). The data port has priority.
//            A starvation counter forces a fetch through after STARVE_LIMIT
//            consecutive contended data wins. Read data comes back one cycle
//            after the grant and is routed to the requester that issued it.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            if_req/if_addr        - fetch request (held until if_gnt)
//            if_gnt/if_rvalid/if_rdata - fetch grant and read return
//            d_req/d_we/d_addr/d_wdata/d_wstrb - data request
//            d_gnt/d_rvalid/d_rdata    - data grant and read return
//            mem_addr/mem_re/mem_we/mem_wdata/mem_wstrb - memory drive
//            mem_rdata             - memory read data (cycle after mem_re)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [63:0]           if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [63:0]           d_wdata,
    input  logic [7:0]            d_wstrb,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [63:0]           d_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [63:0]           mem_wdata,
    output logic [7:0]            mem_wstrb,
    input  logic [63:0]           mem_rdata
);

    localparam logic [3:0] C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;
    logic       r_pend_if;
    logic       r_pend_d;

    logic       w_if_gnt;
    logic       w_d_gnt;

    // Grant: data wins contention unless fetch has been starved long enough.
    // Nothing is granted while reset is asserted.
    always_comb begin
        w_if_gnt = 1'b0;
        w_d_gnt  = 1'b0;
        if (!rst) begin
            if (if_req && d_req) begin
                if (r_starve_cnt == C_STARVE_LIMIT) begin
                    w_if_gnt = 1'b1;
                end else begin
                    w_d_gnt  = 1'b1;
                end
            end else if (if_req) begin
                w_if_gnt = 1'b1;
            end else if (d_req) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    // Memory drive: idle cycles park every memory signal at zero.
    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = 64'h0;
        mem_wstrb = 8'h00;
        if (w_if_gnt) begin
            mem_addr = if_addr;
            mem_re   = 1'b1;
        end else if (w_d_gnt) begin
            mem_addr  = d_addr;
            mem_re    = ~d_we;
            mem_we    = d_we;
            mem_wdata = d_wdata;
            mem_wstrb = d_we ? d_wstrb : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
            r_pend_if    <= 1'b0;
            r_pend_d     <= 1'b0;
        end else begin
            r_pend_if <= w_if_gnt;
            r_pend_d  <= w_d_gnt & ~d_we;
            if (w_if_gnt || !if_req) begin
                r_starve_cnt <= 4'd0;
            end else if (w_d_gnt && r_starve_cnt != C_STARVE_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    assign if_gnt = w_if_gnt;
    assign d_gnt  = w_d_gnt;

    // A read outstanding when reset arrives is dropped immediately: the
    // pending flag is only cleared at the reset edge, so gate it here too.
    assign if_rvalid = r_pend_if & ~rst;
    assign d_rvalid  = r_pend_d & ~rst;
    assign if_rdata  = if_rvalid ? mem_rdata : 64'h0;
    assign d_rdata   = d_rvalid  ? mem_rdata : 64'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: a table of per-cycle
//            vectors followed by hand-written starvation and reset sequences.
//            A behavioural 64-bit memory with byte strobes and one cycle of
//            read latency sits on the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_WIDTH   = 10;
    localparam int STARVE_LIMIT = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [63:0]           if_rdata;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [63:0]           d_wdata;
    logic [7:0]            d_wstrb;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [63:0]           d_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_re;
    logic                  mem_we;
    logic [63:0]           mem_wdata;
    logic [7:0]            mem_wstrb;
    logic [63:0]           mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_addr (mem_addr),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    // Behavioural memory; 'load' preloads the known words on the first edge.
    logic        load = 1'b1;
    logic [63:0] mem [0:(1<<ADDR_WIDTH)-1];

    function automatic logic [63:0] init_word(input int i);
        case (i)
            1:       return 64'hAAAAAAAA11111111;
            2:       return 64'h2222222222222222;
            3:       return 64'h3333333333333333;
            default: return 64'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < (1<<ADDR_WIDTH); i++) mem[i] <= init_word(i);
            mem_rdata <= 64'h0;
        end else begin
            if (mem_we) begin
                for (int b = 0; b < 8; b++)
                    if (mem_wstrb[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic ir, input logic [9:0] ia,
                          input logic dr, input logic dw, input logic [9:0] da,
                          input logic [63:0] dd, input logic [7:0] ds);
        rst = r; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_wstrb = ds;
    endtask

    // Advance one cycle: new inputs just after the edge, sample at negedge.
    task automatic step(input logic r, input logic ir, input logic [9:0] ia,
                        input logic dr, input logic dw, input logic [9:0] da,
                        input logic [63:0] dd, input logic [7:0] ds);
        @(posedge clk);
        #1;
        load = 1'b0;
        set_in(r, ir, ia, dr, dw, da, dd, ds);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [9:0]  if_addr;
        logic        d_req;
        logic        d_we;
        logic [9:0]  d_addr;
        logic [63:0] d_wdata;
        logic [7:0]  d_wstrb;
        logic        e_if_gnt;
        logic        e_d_gnt;
        logic        e_re;
        logic        e_we;
        logic [9:0]  e_addr;
        logic [63:0] e_wdata;
        logic [7:0]  e_wstrb;
        logic        e_if_rv;
        logic [63:0] e_if_rd;
        logic        e_d_rv;
        logic [63:0] e_d_rd;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    initial begin
        // rst, if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb |
        // if_gnt, d_gnt, re, we, addr, wdata, wstrb | if_rv, if_rd, d_rv, d_rd
        vecs[0]  = '{1'b1, 1'b1, 10'h001, 1'b1, 1'b0, 10'h010, 64'h0, 8'h00,
                     1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b0, 64'h0, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b0, 64'h0, 1'b0, 64'h0};
        vecs[2]  = '{1'b0, 1'b1, 10'h001, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b1, 1'b0, 1'b1, 1'b0, 10'h001, 64'h0, 8'h00,
                     1'b0, 64'h0, 1'b0, 64'h0};
        vecs[3]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b1, 64'hAAAAAAAA11111111, 1'b0, 64'h0};
        vecs[4]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h010, 64'h0123456789ABCDEF, 8'h0F,
                     1'b0, 1'b1, 1'b0, 1'b1, 10'h010, 64'h0123456789ABCDEF, 8'h0F,
                     1'b0, 64'h0, 1'b0, 64'h0};
        vecs[5]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h010, 64'h0, 8'h00,
                     1'b0, 1'b1, 1'b1, 1'b0, 10'h010, 64'h0, 8'h00,
                     1'b0, 64'h0, 1'b0, 64'h0};
        vecs[6]  = '{1'b0, 1'b1, 10'h002, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b1, 1'b0, 1'b1, 1'b0, 10'h002, 64'h0, 8'h00,
                     1'b0, 64'h0, 1'b1, 64'h0000000089ABCDEF};
        vecs[7]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h003, 64'h0, 8'h00,
                     1'b0, 1'b1, 1'b1, 1'b0, 10'h003, 64'h0, 8'h00,
                     1'b1, 64'h2222222222222222, 1'b0, 64'h0};
        vecs[8]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b0, 64'h0, 1'b1, 64'h3333333333333333};
        vecs[9]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h003, 64'hFFFFFFFFFFFFFFFF, 8'h00,
                     1'b0, 1'b1, 1'b0, 1'b1, 10'h003, 64'hFFFFFFFFFFFFFFFF, 8'h00,
                     1'b0, 64'h0, 1'b0, 64'h0};
        vecs[10] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h003, 64'h0, 8'h00,
                     1'b0, 1'b1, 1'b1, 1'b0, 10'h003, 64'h0, 8'h00,
                     1'b0, 64'h0, 1'b0, 64'h0};
        vecs[11] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b0, 64'h0, 1'b1, 64'h3333333333333333};
        vecs[12] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h001, 64'h0, 8'hFF,
                     1'b0, 1'b1, 1'b1, 1'b0, 10'h001, 64'h0, 8'h00,
                     1'b0, 64'h0, 1'b0, 64'h0};
        vecs[13] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00,
                     1'b0, 64'h0, 1'b1, 64'hAAAAAAAA11111111};

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            if (i == 0) begin
                set_in(vecs[0].rst, vecs[0].if_req, vecs[0].if_addr, vecs[0].d_req,
                       vecs[0].d_we, vecs[0].d_addr, vecs[0].d_wdata, vecs[0].d_wstrb);
                @(negedge clk);
            end else begin
                step(vecs[i].rst, vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req,
                     vecs[i].d_we, vecs[i].d_addr, vecs[i].d_wdata, vecs[i].d_wstrb);
            end
            chk($sformatf("v%0d if_gnt", i),    64'(if_gnt),    64'(vecs[i].e_if_gnt));
            chk($sformatf("v%0d d_gnt", i),     64'(d_gnt),     64'(vecs[i].e_d_gnt));
            chk($sformatf("v%0d mem_re", i),    64'(mem_re),    64'(vecs[i].e_re));
            chk($sformatf("v%0d mem_we", i),    64'(mem_we),    64'(vecs[i].e_we));
            chk($sformatf("v%0d mem_addr", i),  64'(mem_addr),  64'(vecs[i].e_addr));
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,      vecs[i].e_wdata);
            chk($sformatf("v%0d mem_wstrb", i), 64'(mem_wstrb), 64'(vecs[i].e_wstrb));
            chk($sformatf("v%0d if_rvalid", i), 64'(if_rvalid), 64'(vecs[i].e_if_rv));
            chk($sformatf("v%0d if_rdata", i),  if_rdata,       vecs[i].e_if_rd);
            chk($sformatf("v%0d d_rvalid", i),  64'(d_rvalid),  64'(vecs[i].e_d_rv));
            chk($sformatf("v%0d d_rdata", i),   d_rdata,        vecs[i].e_d_rd);
        end

        // ---------------- starvation: both requesters for 10 cycles ----------------
        // Fetch reads word 1, data reads word 0x10 (0x0000000089ABCDEF).
        begin
            logic prev_if;
            logic prev_valid;
            prev_if    = 1'b0;
            prev_valid = 1'b0;
            for (int k = 0; k < 10; k++) begin
                logic exp_if;
                exp_if = (k == 4) || (k == 9);
                step(1'b0, 1'b1, 10'h001, 1'b1, 1'b0, 10'h010, 64'h0, 8'h00);
                chk($sformatf("starve%0d if_gnt", k), 64'(if_gnt), 64'(exp_if));
                chk($sformatf("starve%0d d_gnt", k),  64'(d_gnt),  64'(!exp_if));
                chk($sformatf("starve%0d both_rvalid", k), 64'(if_rvalid & d_rvalid), 64'h0);
                if (prev_valid) begin
                    chk($sformatf("starve%0d if_rvalid", k), 64'(if_rvalid), 64'(prev_if));
                    chk($sformatf("starve%0d d_rvalid", k),  64'(d_rvalid),  64'(!prev_if));
                    if (prev_if)
                        chk($sformatf("starve%0d if_rdata", k), if_rdata, 64'hAAAAAAAA11111111);
                    else
                        chk($sformatf("starve%0d d_rdata", k), d_rdata, 64'h0000000089ABCDEF);
                end else begin
                    chk($sformatf("starve%0d no_rvalid", k), 64'(if_rvalid | d_rvalid), 64'h0);
                end
                prev_if    = exp_if;
                prev_valid = 1'b1;
            end
        end

        // ---------------- reset with a fetch outstanding ----------------
        step(1'b0, 1'b1, 10'h002, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00);
        chk("rst1 pre if_gnt", 64'(if_gnt), 64'h1);
        step(1'b1, 1'b1, 10'h002, 1'b1, 1'b0, 10'h010, 64'h0, 8'h00);
        chk("rst1 if_rvalid", 64'(if_rvalid), 64'h0);
        chk("rst1 if_rdata",  if_rdata,       64'h0);
        chk("rst1 grants",    64'({if_gnt, d_gnt}),  64'h0);
        chk("rst1 re_we",     64'({mem_re, mem_we}), 64'h0);
        step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00);
        chk("rst1 post rvalid", 64'({if_rvalid, d_rvalid}), 64'h0);

        // ---------------- reset clears the starvation counter ----------------
        // Three data wins push the counter to 3; after reset the data port
        // must win four more times before fetch gets through.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 10'h001, 1'b1, 1'b0, 10'h010, 64'h0, 8'h00);
            chk($sformatf("rst2 pre%0d d_gnt", k), 64'(d_gnt), 64'h1);
        end
        step(1'b1, 1'b1, 10'h001, 1'b1, 1'b0, 10'h010, 64'h0, 8'h00);
        chk("rst2 d_rvalid", 64'(d_rvalid), 64'h0);
        chk("rst2 grants",   64'({if_gnt, d_gnt}), 64'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 10'h001, 1'b1, 1'b0, 10'h010, 64'h0, 8'h00);
            chk($sformatf("rst2 post%0d if_gnt", k), 64'(if_gnt), 64'(k == 4));
            chk($sformatf("rst2 post%0d d_gnt", k),  64'(d_gnt),  64'(k != 4));
            if (k == 0)
                chk("rst2 post0 rvalid", 64'({if_rvalid, d_rvalid}), 64'h0);
        end

        // ---------------- idle after traffic ----------------
        step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00);
        chk("idle re_we", 64'({mem_re, mem_we}), 64'h0);
        step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 64'h0, 8'h00);
        chk("idle rvalid", 64'({if_rvalid, d_rvalid}), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
